// File: rtl/arith_pkg.sv
// Shared arithmetic constants: operand/product widths and the multiplier FSM encodings.
package arith_pkg;

  localparam int MUL_W  = 16;
  localparam int PROD_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit ripple-carry adder: sum = x + y + c_in, carry out on c_out.
module full_adder_32bit
  import arith_pkg::*;
(
  input  logic [PROD_W-1:0] x,
  input  logic [PROD_W-1:0] y,
  input  logic              c_in,
  output logic [PROD_W-1:0] sum,
  output logic              c_out
);

  logic carry;

  // Ripple the carry from bit 0 upward, one full adder per bit.
  always_comb begin
    carry = c_in;
    sum   = '0;
    for (int unsigned i = 0; i < PROD_W; i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
  end

  assign c_out = carry;

endmodule

// File: rtl/seq_multiplier_16bit.sv
// Unsigned 16x16 -> 32 shift-add multiplier with start/busy/done handshake.
// One iteration per clock through full_adder_32bit; 16 iterations per product.
module seq_multiplier_16bit
  import arith_pkg::*;
#(
  parameter int WIDTH = MUL_W  // only 16 is legal: the adder is fixed at 32 bits
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [1:0]          state;
  logic [PROD_W-1:0]   mcand;
  logic [WIDTH-1:0]    mplier;
  logic [PROD_W-1:0]   acc;
  logic [3:0]          cnt;
  logic [PROD_W-1:0]   sum;
  logic                c_out_unused;  // a 16x16 product never overflows 32 bits

  full_adder_32bit u_adder (
    .x     (acc),
    .y     (mcand),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out_unused)
  );

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // FSM, operand shift registers, accumulator, iteration counter and product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{(PROD_W-WIDTH){1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mplier[0]) acc <= sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            product <= mplier[0] ? sum : acc;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          // The DONE->IDLE edge doubles as an IDLE edge for start, so a held start
          // yields one operation every 17 cycles; start seen earlier in RUN is dropped.
          if (start) begin
            mcand  <= {{(PROD_W-WIDTH){1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_16bit.sv
// Self-checking bench for seq_multiplier_16bit: vector table, random ops vs a*b, and
// hand-written handshake / reset / back-to-back sequences.
module tb_seq_multiplier_16bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  seq_multiplier_16bit #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: the product is just the unsigned arithmetic product.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

  // Issue one operation and check busy/done timing and the result.
  // inj > 0: assert a competing start (a=2,b=2) for one cycle at iteration inj.
  task automatic do_op(input string nm, input logic [15:0] opa, input logic [15:0] opb,
                       input logic [31:0] exp, input int inj);
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; a = opa; b = opb;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (inj > 0 && k == inj) begin start = 1'b1; a = 16'd2; b = 16'd2; end
      if (inj > 0 && k == inj + 1) start = 1'b0;
      if (done) dones++;
      if (k < 16) check({nm, " busy_run"}, {30'd0, busy, done}, 32'b10);
      if (k == 16) begin
        check({nm, " done_pulse"}, {30'd0, busy, done}, 32'b01);
        check({nm, " product"}, product, exp);
      end
      if (k == 17) check({nm, " idle_after"}, {30'd0, busy, done}, 32'b00);
      if (k == 20) check({nm, " product_held"}, product, exp);
    end
    check({nm, " done_count"}, 32'(dones), 32'd1);
  endtask

  vec_t vecs[$];
  logic [15:0] ra, rb;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("reset_outputs", {busy, done, 30'd0}, 32'd0);
    check("reset_product", product, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"3x5",       16'h0003, 16'h0005, 32'h0000000F});
    vecs.push_back('{"max",       16'hFFFF, 16'hFFFF, 32'hFFFE0001});
    vecs.push_back('{"zero_a",    16'h0000, 16'h1234, 32'h00000000});
    vecs.push_back('{"zero_b",    16'h1234, 16'h0000, 32'h00000000});
    vecs.push_back('{"msb_x2",    16'h8000, 16'h0002, 32'h00010000});
    vecs.push_back('{"alt_bits",  16'hAAAA, 16'h5555, 32'h38E31C72});
    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p, 0);

    // Start asserted mid-run must be ignored.
    do_op("ignore_start", 16'h00FF, 16'h0101, 32'h0000FFFF, 5);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      do_op("random", ra, rb, ref_mul(ra, rb), 0);
    end

    // Asynchronous reset in the middle of a run discards it.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin @(posedge clk); #1; end
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_flags", {30'd0, busy, done}, 32'd0);
    check("async_reset_product", product, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("reset_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_reset", 16'h0007, 16'h0006, 32'h0000002A, 0);

    // start held high: back-to-back operations 17 cycles apart.
    @(negedge clk);
    start = 1'b1; a = 16'd2; b = 16'd3;
    @(posedge clk); #1;
    a = 16'h8000; b = 16'h0002;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #1;
      if (k == 17) start = 1'b0;
      check("b2b_done", {31'd0, done}, (k == 16 || k == 33) ? 32'd1 : 32'd0);
      if (k == 16) check("b2b_first", product, 32'h00000006);
      if (k == 25) check("b2b_hold", product, 32'h00000006);
      if (k == 33) check("b2b_second", product, 32'h00010000);
      if (k == 36) check("b2b_idle", {30'd0, busy, done}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
